// File: rtl/ser_pkg.sv
// Shared types and constants for the parallel-to-serial serializer family.
package ser_pkg;

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } ser_state_t;

    localparam logic [7:0] SYM_IDLE  = 8'hBC;
    localparam logic [7:0] SYM_TRAIN = 8'h7C;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p2s_serializer_n_if.sv
// Parallel word side and serial side of the serializer, bundled for port lists.
interface p2s_serializer_n_if #(
    parameter int LANES = 2,
    parameter int WIDTH = 8
);
    logic [LANES*WIDTH-1:0] data_in;
    logic [LANES-1:0]       valid_in;
    logic                   ready;
    logic [LANES-1:0]       data_out;
    logic                   sym_start;
    logic                   trained;

    modport master (
        output data_in, valid_in,
        input  ready, data_out, sym_start, trained
    );

    modport slave (
        input  data_in, valid_in,
        output ready, data_out, sym_start, trained
    );
endinterface

// File: rtl/p2s_lane.sv
// One serial lane: WIDTH-bit shift register that loads a symbol and shifts it out MSB first.
module p2s_lane
    import ser_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(SYM_IDLE),
    parameter logic [WIDTH-1:0] TRAIN_SYM = WIDTH'(SYM_TRAIN)
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             load,
    input  logic             train,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] load_word;

    // NOTE: default assigned first so every path drives load_word and no latch is inferred.
    always_comb begin
        load_word = IDLE_SYM;
        if (train)
            load_word = TRAIN_SYM;
        else if (valid)
            load_word = data;
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk_8f) begin
        // NOTE: the shift register is reset so the line sits at 0 while reset is held.
        if (reset)
            sr <= '0;
        else if (load)
            sr <= load_word;
        else
            sr <= {sr[WIDTH-2:0], 1'b0};
    end

    assign bit_out = sr[WIDTH-1];

endmodule

// File: rtl/p2s_serializer_n.sv
// LANES x WIDTH parallel-to-serial serializer with shared bit counter.
// Optional post-reset training sequence enabled by defining SER_TRAIN_EN.
module p2s_serializer_n
    import ser_pkg::*;
#(
    parameter int               LANES      = 2,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(SYM_IDLE),
    parameter logic [WIDTH-1:0] TRAIN_SYM  = WIDTH'(SYM_TRAIN),
    parameter int               TRAIN_SYMS = 4
) (
    input logic               clk_8f,
    input logic               reset,
    p2s_serializer_n_if.slave bus
);

`ifdef SER_TRAIN_EN
    localparam bit TRAIN_ON = (TRAIN_SYMS > 0);
`else
    localparam bit TRAIN_ON = 1'b0;
`endif

    localparam int            CW       = cnt_width(WIDTH);
    localparam int            TW       = cnt_width(TRAIN_SYMS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic             load;
    logic             sym_start_q;
    ser_state_t       state, state_next;
    logic [TW-1:0]    train_cnt, train_cnt_next;
    logic [LANES-1:0] serial;

    assign load = (cnt == '0);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            cnt         <= '0;
            sym_start_q <= 1'b0;
        end else begin
            cnt         <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            sym_start_q <= load;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= TRAIN_ON ? TRAIN : RUN;
            train_cnt <= '0;
        end else begin
            state     <= state_next;
            train_cnt <= train_cnt_next;
        end
    end

    // Leave TRAIN on the last bit of the final training symbol so the next load carries data.
    always_comb begin
        state_next     = state;
        train_cnt_next = train_cnt;
        if (state == TRAIN) begin
            if (load)
                train_cnt_next = train_cnt + TW'(1);
            if (cnt == CNT_LAST && train_cnt == TW'(TRAIN_SYMS))
                state_next = RUN;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        p2s_lane #(
            .WIDTH     (WIDTH),
            .IDLE_SYM  (IDLE_SYM),
            .TRAIN_SYM (TRAIN_SYM)
        ) u_lane (
            .clk_8f  (clk_8f),
            .reset   (reset),
            .load    (load),
            .train   (state == TRAIN),
            .valid   (bus.valid_in[k]),
            .data    (bus.data_in[k*WIDTH +: WIDTH]),
            .bit_out (serial[k])
        );
    end

    assign bus.data_out  = serial;
    assign bus.sym_start = sym_start_q;
    assign bus.ready     = load && (state == RUN) && !reset;

`ifdef SER_TRAIN_EN
    assign bus.trained = (state == RUN);
`else
    assign bus.trained = 1'b1;
`endif

endmodule

// File: tb/tb_p2s_serializer_n.sv
// Bench for p2s_serializer_n: a 2x8 and a 4x10 instance against a symbol-timeline model.
module tb_p2s_serializer_n;

    localparam int LA = 2, WA = 8, LB = 4, WB = 10;
    localparam int TSYMS = 4;
`ifdef SER_TRAIN_EN
    localparam int NTRAIN = TSYMS;
`else
    localparam int NTRAIN = 0;
`endif
    localparam logic [WA-1:0] IDLE_A = 8'hBC,   TRAIN_A = 8'h7C;
    localparam logic [WB-1:0] IDLE_B = 10'h0BC, TRAIN_B = 10'h07C;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_8f = ~clk_8f;

    p2s_serializer_n_if #(.LANES(LA), .WIDTH(WA)) bus_a();
    p2s_serializer_n_if #(.LANES(LB), .WIDTH(WB)) bus_b();

    p2s_serializer_n #(.LANES(LA), .WIDTH(WA), .TRAIN_SYMS(TSYMS)) dut_a (
        .clk_8f (clk_8f), .reset (reset), .bus (bus_a)
    );
    p2s_serializer_n #(.LANES(LB), .WIDTH(WB), .IDLE_SYM(IDLE_B), .TRAIN_SYM(TRAIN_B),
                       .TRAIN_SYMS(TSYMS)) dut_b (
        .clk_8f (clk_8f), .reset (reset), .bus (bus_b)
    );

    // Model: edges since reset release; symbol n occupies edges n*W .. n*W+W-1.
    int ea = -1, eb = -1;
    logic [WA-1:0] wa [LA];
    logic [WB-1:0] wb [LB];

    always @(posedge clk_8f) begin
        if (reset) begin
            ea = -1;
            eb = -1;
        end else begin
            ea = ea + 1;
            eb = eb + 1;
            if (ea % WA == 0)
                for (int k = 0; k < LA; k++)
                    wa[k] = (ea / WA < NTRAIN) ? TRAIN_A :
                            bus_a.valid_in[k] ? bus_a.data_in[k*WA +: WA] : IDLE_A;
            if (eb % WB == 0)
                for (int k = 0; k < LB; k++)
                    wb[k] = (eb / WB < NTRAIN) ? TRAIN_B :
                            bus_b.valid_in[k] ? bus_b.data_in[k*WB +: WB] : IDLE_B;
        end
    end

    // Expected {ready, trained, sym_start, data_out} in the current cycle.
    function automatic logic [LA+2:0] exp_a();
        logic [LA-1:0] d;
        int ph;
        ph = (ea < 0) ? 0 : ea % WA;
        for (int k = 0; k < LA; k++) d[k] = (ea < 0) ? 1'b0 : wa[k][WA-1-ph];
        return {!reset && ((ea + 1) % WA == 0) && ((ea + 1) / WA >= NTRAIN),
                (ea + 1) >= NTRAIN * WA, (ea >= 0) && (ph == 0), d};
    endfunction

    function automatic logic [LB+2:0] exp_b();
        logic [LB-1:0] d;
        int ph;
        ph = (eb < 0) ? 0 : eb % WB;
        for (int k = 0; k < LB; k++) d[k] = (eb < 0) ? 1'b0 : wb[k][WB-1-ph];
        return {!reset && ((eb + 1) % WB == 0) && ((eb + 1) / WB >= NTRAIN),
                (eb + 1) >= NTRAIN * WB, (eb >= 0) && (ph == 0), d};
    endfunction

    function automatic logic [LA+2:0] act_a();
        return {bus_a.ready, bus_a.trained, bus_a.sym_start, bus_a.data_out};
    endfunction

    function automatic logic [LB+2:0] act_b();
        return {bus_b.ready, bus_b.trained, bus_b.sym_start, bus_b.data_out};
    endfunction

    task automatic wait_ready_a();
        int n = 0;
        while (bus_a.ready !== 1'b1 && n < 200) begin
            @(negedge clk_8f);
            n++;
        end
        checks++;
        if (bus_a.ready !== 1'b1) begin
            errors++;
            $display("FAIL a_ready_timeout got %b want 1 after %0d cycles", bus_a.ready, n);
        end
    endtask

    task automatic wait_ready_b();
        int n = 0;
        while (bus_b.ready !== 1'b1 && n < 200) begin
            @(negedge clk_8f);
            n++;
        end
        checks++;
        if (bus_b.ready !== 1'b1) begin
            errors++;
            $display("FAIL b_ready_timeout got %b want 1 after %0d cycles", bus_b.ready, n);
        end
    endtask

    task automatic test_reset();
        logic [LA+2:0] rst_a;
        rst_a = {1'b0, NTRAIN == 0, 1'b0, {LA{1'b0}}};
        repeat (3) begin
            @(negedge clk_8f);
            checks++;
            if (act_a() !== rst_a) begin
                errors++;
                $display("FAIL reset_a got %b want %b", act_a(), rst_a);
            end
            checks++;
            if (act_b() !== exp_b()) begin
                errors++;
                $display("FAIL reset_b got %b want %b", act_b(), exp_b());
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus_a.ready !== (NTRAIN == 0)) begin
            errors++;
            $display("FAIL release_ready got %b want %b", bus_a.ready, NTRAIN == 0);
        end
    endtask

    task automatic test_training();
        for (int i = 0; i < NTRAIN * WA; i++) begin
            @(negedge clk_8f);
            checks++;
            if (act_a() !== exp_a()) begin
                errors++;
                $display("FAIL train_a edge=%0d got %b want %b", ea, act_a(), exp_a());
            end
        end
    endtask

    task automatic test_basic();
        logic [WA-1:0] b0, b1;
        wait_ready_a();
        bus_a.data_in  = {8'h3C, 8'hA5};
        bus_a.valid_in = 2'b11;
        for (int i = 0; i < WA; i++) begin
            @(negedge clk_8f);
            b0[WA-1-i] = bus_a.data_out[0];
            b1[WA-1-i] = bus_a.data_out[1];
            checks++;
            if (act_a() !== exp_a()) begin
                errors++;
                $display("FAIL basic_a edge=%0d got %b want %b", ea, act_a(), exp_a());
            end
        end
        checks++;
        if (b0 !== 8'hA5 || b1 !== 8'h3C) begin
            errors++;
            $display("FAIL basic_bits got %h/%h want a5/3c", b0, b1);
        end
    endtask

    task automatic test_idle();
        logic [WA-1:0] b0, b1;
        wait_ready_a();
        bus_a.data_in  = {8'hFF, 8'h5A};
        bus_a.valid_in = 2'b01;
        for (int i = 0; i < WA; i++) begin
            @(negedge clk_8f);
            b0[WA-1-i] = bus_a.data_out[0];
            b1[WA-1-i] = bus_a.data_out[1];
            checks++;
            if (act_a() !== exp_a()) begin
                errors++;
                $display("FAIL idle_a edge=%0d got %b want %b", ea, act_a(), exp_a());
            end
        end
        checks++;
        if (b0 !== 8'h5A || b1 !== 8'hBC) begin
            errors++;
            $display("FAIL idle_bits got %h/%h want 5a/bc", b0, b1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits, starts;
        wait_ready_a();
        bus_a.data_in  = {8'h00, 8'h01};
        bus_a.valid_in = 2'b01;
        for (int i = 0; i < 2 * WA; i++) begin
            @(negedge clk_8f);
            bits[15-i]   = bus_a.data_out[0];
            starts[15-i] = bus_a.sym_start;
            checks++;
            if (act_a() !== exp_a()) begin
                errors++;
                $display("FAIL b2b_a edge=%0d got %b want %b", ea, act_a(), exp_a());
            end
            if (i == WA - 1) bus_a.data_in = {8'h00, 8'h80};
        end
        checks++;
        if (bits !== 16'h0180 || starts !== 16'h8080) begin
            errors++;
            $display("FAIL b2b_stream got %h/%h want 0180/8080", bits, starts);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40 * WA; i++) begin
            @(negedge clk_8f);
            checks++;
            if (act_a() !== exp_a()) begin
                errors++;
                $display("FAIL rand_a edge=%0d got %b want %b", ea, act_a(), exp_a());
            end
            bus_a.data_in  = 16'($urandom);
            bus_a.valid_in = 2'($urandom);
        end
    endtask

    task automatic test_reset_mid();
        wait_ready_a();
        bus_a.data_in  = {8'hC3, 8'h96};
        bus_a.valid_in = 2'b11;
        repeat (3) @(negedge clk_8f);
        reset = 1'b1;
        @(negedge clk_8f);
        checks++;
        if (bus_a.data_out !== 2'b00 || bus_a.sym_start !== 1'b0 || act_a() !== exp_a()) begin
            errors++;
            $display("FAIL mid_reset got %b want %b", act_a(), exp_a());
        end
        reset = 1'b0;
        for (int i = 0; i < WA; i++) begin
            @(negedge clk_8f);
            checks++;
            if (act_a() !== exp_a() || (i == 0 && bus_a.sym_start !== 1'b1)) begin
                errors++;
                $display("FAIL mid_restart edge=%0d got %b want %b", ea, act_a(), exp_a());
            end
        end
    endtask

    task automatic test_wide();
        logic [WB-1:0] bits [LB];
        int n;
        wait_ready_b();
        bus_b.data_in  = {LB{10'h2AA}};
        bus_b.valid_in = '1;
        for (int i = 0; i < WB; i++) begin
            @(negedge clk_8f);
            for (int k = 0; k < LB; k++) bits[k][WB-1-i] = bus_b.data_out[k];
            checks++;
            if (act_b() !== exp_b()) begin
                errors++;
                $display("FAIL wide_b edge=%0d got %b want %b", eb, act_b(), exp_b());
            end
        end
        for (int k = 0; k < LB; k++) begin
            checks++;
            if (bits[k] !== 10'h2AA) begin
                errors++;
                $display("FAIL wide_lane%0d got %h want 2aa", k, bits[k]);
            end
        end
        n = 0;
        do begin
            @(negedge clk_8f);
            n++;
        end while (bus_b.ready !== 1'b1 && n < 50);
        checks++;
        if (n != WB) begin
            errors++;
            $display("FAIL wide_ready_period got %0d want %0d", n, WB);
        end
        for (int i = 0; i < 10 * WB; i++) begin
            @(negedge clk_8f);
            checks++;
            if (act_b() !== exp_b()) begin
                errors++;
                $display("FAIL rand_b edge=%0d got %b want %b", eb, act_b(), exp_b());
            end
            bus_b.data_in  = 40'({$urandom, $urandom});
            bus_b.valid_in = 4'($urandom);
        end
    endtask

    initial begin
        bus_a.data_in  = '0;
        bus_a.valid_in = '0;
        bus_b.data_in  = '0;
        bus_b.valid_in = '0;
        test_reset();
        test_training();
        test_basic();
        test_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
